// File: rtl/bouncing_box_renderer_if.sv
// bouncing_box_renderer_if: scan coordinates in, composited colour and sprite state out.
interface bouncing_box_renderer_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] bg_color;
    logic       enable;
    logic [7:0] color_out;
    logic       frame_tick;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [7:0] bounce_count;
    modport master (
        output pixel_x, pixel_y, bg_color, enable,
        input  color_out, frame_tick, box_x, box_y, bounce_count
    );
    modport slave (
        input  pixel_x, pixel_y, bg_color, enable,
        output color_out, frame_tick, box_x, box_y, bounce_count
    );
endinterface

// File: rtl/bouncing_box_renderer.sv
// bouncing_box_renderer: composites a bouncing square sprite over a background colour,
// advancing the sprite once per frame as the scan leaves the last active line.
module bouncing_box_renderer #(
    parameter int         SCREEN_W  = 640,
    parameter int         SCREEN_H  = 480,
    parameter int         BOX_SIZE  = 32,
    parameter int         STEP      = 2,
    parameter int         INIT_X    = 0,
    parameter int         INIT_Y    = 0,
    parameter logic [7:0] BOX_COLOR = 8'hE0
) (
    input logic                    clk_25mhz,
    input logic                    reset,
    bouncing_box_renderer_if.slave bus
);
    localparam logic [10:0] MAX_X  = 11'(SCREEN_W - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(SCREEN_H - BOX_SIZE);
    localparam logic [10:0] STP    = 11'(STEP);
    localparam logic [10:0] SZ     = 11'(BOX_SIZE);
    localparam logic [10:0] SCR_W  = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H  = 11'(SCREEN_H);
    localparam logic [9:0]  LAST_Y = 10'(SCREEN_H - 1);

    logic [9:0]  r_prev_y, r_box_x, r_box_y;
    logic        r_left, r_up, r_tick;
    logic [7:0]  r_color, r_count, r_out;
    logic [10:0] w_px, w_py, w_bx, w_by;
    logic [9:0]  w_nx, w_ny;
    logic        w_boundary, w_move, w_inside, w_hit_x, w_hit_y, w_bounce;

    // 11-bit views keep box+BOX_SIZE and box+STEP from wrapping
    always_comb begin
        w_px       = {1'b0, bus.pixel_x};
        w_py       = {1'b0, bus.pixel_y};
        w_bx       = {1'b0, r_box_x};
        w_by       = {1'b0, r_box_y};
        w_boundary = (r_prev_y == LAST_Y) && (bus.pixel_y != LAST_Y);
        w_move     = w_boundary && bus.enable;
        w_inside   = (w_px >= w_bx) && (w_px < w_bx + SZ) && (w_py >= w_by) && (w_py < w_by + SZ)
                     && (w_px < SCR_W) && (w_py < SCR_H);
        w_hit_x    = r_left ? (w_bx <= STP) : (w_bx + STP >= MAX_X);
        w_hit_y    = r_up   ? (w_by <= STP) : (w_by + STP >= MAX_Y);
        w_nx       = 10'(w_hit_x ? (r_left ? 11'd0 : MAX_X) : (r_left ? w_bx - STP : w_bx + STP));
        w_ny       = 10'(w_hit_y ? (r_up   ? 11'd0 : MAX_Y) : (r_up   ? w_by - STP : w_by + STP));
        w_bounce   = w_move && (w_hit_x || w_hit_y);
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_prev_y <= '0;
            r_box_x  <= 10'(INIT_X);
            r_box_y  <= 10'(INIT_Y);
            r_left   <= 1'b0;
            r_up     <= 1'b0;
            r_tick   <= 1'b0;
            r_color  <= BOX_COLOR;
            r_count  <= '0;
            r_out    <= '0;
        end else begin
            r_prev_y <= bus.pixel_y;
            r_tick   <= w_boundary;
            r_out    <= w_inside ? r_color : bus.bg_color;
            if (w_move) begin
                r_box_x <= w_nx;
                r_box_y <= w_ny;
                r_left  <= r_left ^ w_hit_x;
                r_up    <= r_up ^ w_hit_y;
            end
            if (w_bounce) begin
                r_count <= r_count + 8'd1;
                r_color <= {r_color[4:0], r_color[7:5]};
            end
        end
    end

    assign bus.color_out    = r_out;
    assign bus.frame_tick   = r_tick;
    assign bus.box_x        = r_box_x;
    assign bus.box_y        = r_box_y;
    assign bus.bounce_count = r_count;
endmodule

// File: doc/bouncing_box_renderer.md
# bouncing_box_renderer

Pixel colour generator that sits directly upstream of `vga_driver`. It consumes the driver's `next_x`/`next_y` scan coordinates and produces the 8-bit RRRGGGBB `color_in` word. A solid square sprite is composited over a caller-supplied background colour. Once per frame, at the end of the active area, the sprite advances by a fixed step, bounces off the screen edges, and rotates its colour on each bounce.

## Interface
Parameters:
- SCREEN_W, 640, active width in pixels
- SCREEN_H, 480, active height in lines
- BOX_SIZE, 32, sprite edge length in pixels
- STEP, 2, pixels moved per frame on each axis; legal range 1..BOX_SIZE-1
- INIT_X, 0, reset X of the sprite's top-left corner; must be ≤ SCREEN_W-BOX_SIZE
- INIT_Y, 0, reset Y of the sprite's top-left corner; must be ≤ SCREEN_H-BOX_SIZE
- BOX_COLOR, 8'hE0, reset sprite colour (RRRGGGBB)

Ports:
- clk_25mhz  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pixel_x  in  10  scan X, from vga_driver next_x
- pixel_y  in  10  scan Y, from vga_driver next_y
- bg_color  in  8  background colour for the current pixel
- enable  in  1  1 = motion runs; 0 = sprite frozen
- color_out  out  8  composited colour, to vga_driver color_in
- frame_tick  out  1  one-cycle pulse per frame boundary
- box_x  out  10  current sprite X
- box_y  out  10  current sprite Y
- bounce_count  out  8  bounce event counter, wraps at 256

## Operation
- Reset values:
  - color_out = 0, frame_tick = 0, bounce_count = 0
  - box_x = INIT_X, box_y = INIT_Y
  - dir_x = right, dir_y = down
  - sprite colour = BOX_COLOR
  - prev_y = 0
- Frame boundary detection:
  - prev_y registers pixel_y every cycle.
  - A boundary occurs when prev_y == SCREEN_H-1 and pixel_y != SCREEN_H-1.
- Compositing:
  - inside = pixel_x in [box_x, box_x+BOX_SIZE) and pixel_y in [box_y, box_y+BOX_SIZE) and pixel_x < SCREEN_W and pixel_y < SCREEN_H.
  - color_out <= inside ? sprite colour : bg_color.
  - Comparisons use 11-bit arithmetic so box_x+BOX_SIZE cannot overflow.
- Motion runs on a boundary cycle with enable=1; X and Y are evaluated independently.
  - Moving right: if box_x+STEP ≥ SCREEN_W-BOX_SIZE, clamp box_x to SCREEN_W-BOX_SIZE and set dir_x to left; otherwise box_x += STEP.
  - Moving left: if box_x ≤ STEP, clamp box_x to 0 and set dir_x to right; otherwise box_x -= STEP.
  - Y follows the same rules against SCREEN_H-BOX_SIZE, using down/up.
- Bounce event: set when at least one axis flips on a frame. A corner hit, where both axes flip, counts as one event.
  - On a bounce event: bounce_count += 1 (mod 256).
  - On a bounce event: sprite colour <= {colour[4:0], colour[7:5]}.
- With enable=0: frame_tick still pulses; position, direction, colour and count hold.

## Timing
- color_out has 1-cycle latency from pixel_x, pixel_y and bg_color. Feed bg_color aligned with the same pixel_x/pixel_y.
- frame_tick is registered and is high for exactly the cycle after the boundary is detected.
- box_x, box_y, direction, colour and bounce_count update on the same clock edge that raises frame_tick.
- The update happens in blanking, so no tearing occurs within the active area.
- reset has priority over every other input on the same edge. Asserting reset mid-frame returns all state to reset values at the next edge, and frame_tick is forced to 0.
- If pixel_y stays at SCREEN_H-1, no boundary fires. At most one boundary fires per exit from line SCREEN_H-1.

## Test plan
- Reset: hold reset 3 cycles with random pixel inputs. Required: color_out=0, box_x=0, box_y=0, bounce_count=0, frame_tick=0.
- Render: defaults, bg_color=8'h03.
  - Drive (31,31); one cycle later color_out=8'hE0.
  - Drive (32,0); one cycle later color_out=8'h03.
  - Drive (700,10); one cycle later color_out=8'h03.
- Motion: drive pixel_y 479 then 480. Required: frame_tick=1 for exactly 1 cycle; box_x=2, box_y=2.
- Bounces: run 305 frames with enable=1.
  - Frame 224: box_y=448, bounce_count=1, colour=8'h07.
  - Frame 225: box_y=446.
  - Frame 304: box_x=608, bounce_count=2, colour=8'h38.
  - Frame 305: box_x=606.
- Freeze: enable=0 for 10 frames. Required: 10 frame_tick pulses; box_x, box_y and bounce_count unchanged.
- Mid-operation reset: after 50 frames, pulse reset for 1 cycle mid-line. Required: box_x=0, box_y=0, colour=8'hE0, count=0. Next boundary gives box_x=2.
